bus_reader: RTL and testbench
=============================

# bus_reader

Registered read side of the datapath bus. It accepts a one-hot "Out" select naming one register source and snapshots that source's value. It then drives the value onto BusMuxOut with a valid/ack handshake, so every register that loads from the bus sees a stable value. It sits between the register file/special registers (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) and the bus consumers. It also flags illegal select patterns.

## Interface
- DATA_WIDTH, 32, width of each source and of the bus
- NUM_SRC, 24, number of bus sources; index order is fixed by the shared package
- CNT_WIDTH, 16, width of the transfer counter

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  reset, synchronous, active-low
- req_valid  in  1  a read request is presented
- req_sel  in  NUM_SRC  one-hot source select (the Out strobes)
- req_ready  out  1  request accepted this cycle when high together with req_valid
- src_data  in  NUM_SRC*DATA_WIDTH  flattened source values; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- BusMuxOut  out  DATA_WIDTH  registered bus value
- bus_src  out  5  encoded index of the source currently driven
- bus_valid  out  1  BusMuxOut holds an accepted transfer
- bus_ack  in  1  consumer has loaded BusMuxOut
- sel_error  out  1  sticky; set on a zero-hot or multi-hot req_sel at accept
- err_clr  in  1  clears sel_error
- xfer_count  out  CNT_WIDTH  number of completed transfers (acks), wraps

## Operation
- States: IDLE (bus_valid=0) and DRIVE (bus_valid=1).
- req_ready = (state==IDLE) | (state==DRIVE & bus_ack). This is combinational from state and bus_ack only, never from req_valid.
- On accept (req_valid & req_ready):
  - Encode req_sel, with the lowest set index winning.
  - Latch BusMuxOut = src_data[idx] and bus_src = idx.
  - Next state is DRIVE.
- Zero-hot req_sel at accept: BusMuxOut=0, bus_src=0, sel_error set. The transfer still proceeds to DRIVE.
- Multi-hot req_sel at accept: lowest index driven, sel_error set.
- In DRIVE without bus_ack: BusMuxOut and bus_src hold. src_data changes are ignored (snapshot semantics).
- In DRIVE with bus_ack:
  - xfer_count increments.
  - With a simultaneous accept: stay in DRIVE with the new data (back-to-back, no bubble).
  - Otherwise: go to IDLE. BusMuxOut holds its last value, and bus_valid drops.
- bus_ack in IDLE is ignored; it does not count.
- sel_error priority: clear_n over a new error over err_clr. If err_clr and a new error land in the same cycle, the flag stays set.
- xfer_count wraps from 2^CNT_WIDTH−1 to 0.

## Timing
- Reset (clear_n=0 at a rising edge): state=IDLE, BusMuxOut=0, bus_src=0, bus_valid=0, sel_error=0, xfer_count=0.
  - req_ready is 1 in the first cycle after reset.
  - Reset mid-transfer abandons the transfer and does not count it.
- Latency: accept at edge N gives bus_valid=1 and the data visible after edge N. That is 1 cycle.
- Throughput: 1 transfer per cycle when bus_ack is held high and req_valid is held high.
- All outputs except req_ready are registered.

## Structure
- Shared package bus_pkg:
  - DATA_WIDTH and NUM_SRC defaults
  - source index constants: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_CSIGN=23
  - state encoding IDLE/DRIVE
- Sub-module bus_encoder: combinational priority encoder from NUM_SRC one-hot to a 5-bit index, plus a zero_hot flag and a multi_hot flag. It is instantiated once.

## Test plan
- Reset then single read: req_sel=1<<SRC_PC, src PC=32'h0000_0040, bus_ack high next cycle → bus_valid rises 1 cycle after accept, BusMuxOut=32'h40, bus_src=20, xfer_count=1, then IDLE.
- Hold under backpressure: accept R5=32'hDEAD_BEEF, keep bus_ack=0 for 4 cycles while changing R5 to 32'h1234 → BusMuxOut stays 32'hDEAD_BEEF, req_ready=0 throughout, and the count is unchanged until the ack.
- Back-to-back: hold req_valid=1 and bus_ack=1 over 3 requests (R1=1, R2=2, R3=3) → BusMuxOut sequence is 1,2,3 on consecutive cycles, bus_valid never drops, xfer_count=3.
- Illegal selects: req_sel=0 → BusMuxOut=0, sel_error=1. Next, req_sel with bits 3 and 17 set (R3=7, LO=9) → BusMuxOut=7, bus_src=3. err_clr alone → sel_error=0. err_clr together with a new multi-hot select → sel_error=1.
- Counter wrap: CNT_WIDTH=4, complete 17 transfers → xfer_count=1.
- Reset mid-operation: accept MDR=32'hCAFE, assert clear_n=0 before the ack → all outputs return to reset values, xfer_count=0, and req_ready=1 on the next cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus read side: widths, source index
// map and the reader state encoding.
package bus_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_SRC    = 24;

  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R1     = 5'd1;
  localparam logic [4:0] SRC_R2     = 5'd2;
  localparam logic [4:0] SRC_R3     = 5'd3;
  localparam logic [4:0] SRC_R4     = 5'd4;
  localparam logic [4:0] SRC_R5     = 5'd5;
  localparam logic [4:0] SRC_R6     = 5'd6;
  localparam logic [4:0] SRC_R7     = 5'd7;
  localparam logic [4:0] SRC_R8     = 5'd8;
  localparam logic [4:0] SRC_R9     = 5'd9;
  localparam logic [4:0] SRC_R10    = 5'd10;
  localparam logic [4:0] SRC_R11    = 5'd11;
  localparam logic [4:0] SRC_R12    = 5'd12;
  localparam logic [4:0] SRC_R13    = 5'd13;
  localparam logic [4:0] SRC_R14    = 5'd14;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bus_encoder.sv
// Priority encoder for the Out strobes: lowest set index wins, with flags
// for the illegal zero-hot and multi-hot patterns.
module bus_encoder #(
  parameter int NUM_SRC = 24
) (
  input  logic [NUM_SRC-1:0] sel,
  output logic [4:0]         idx,
  output logic               zero_hot,
  output logic               multi_hot
);

  // Scan from the top down so the lowest set index is the last to write idx.
  always_comb begin
    idx = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (sel[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    zero_hot  = (sel == {NUM_SRC{1'b0}});
    multi_hot = ((sel & (sel - {{(NUM_SRC-1){1'b0}}, 1'b1})) != {NUM_SRC{1'b0}});
  end

endmodule

// File: rtl/bus_reader.sv
// Registered bus read port: snapshots the selected source on accept and holds
// it on BusMuxOut until the consumer acks, counting completed transfers.
module bus_reader #(
  parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH,
  parameter int NUM_SRC    = bus_pkg::NUM_SRC,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic                          req_valid,
  input  logic [NUM_SRC-1:0]            req_sel,
  output logic                          req_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [DATA_WIDTH-1:0]         BusMuxOut,
  output logic [4:0]                    bus_src,
  output logic                          bus_valid,
  input  logic                          bus_ack,
  output logic                          sel_error,
  input  logic                          err_clr,
  output logic [CNT_WIDTH-1:0]          xfer_count
);

  import bus_pkg::*;

  state_t                  state_r, state_next_s;
  logic                    req_ready_s, accept_s, ack_s;
  logic [4:0]              enc_idx_s;
  logic                    zero_hot_s, multi_hot_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic [DATA_WIDTH-1:0]   bus_data_r;
  logic [4:0]              bus_src_r;
  logic                    bus_valid_r;
  logic                    sel_error_r;
  logic [CNT_WIDTH-1:0]    xfer_count_r;

  bus_encoder #(.NUM_SRC(NUM_SRC)) u_enc (
    .sel       (req_sel),
    .idx       (enc_idx_s),
    .zero_hot  (zero_hot_s),
    .multi_hot (multi_hot_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: an ack with a fresh accept keeps DRIVE for back-to-back transfers.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_next_s = DRIVE;
        else           state_next_s = IDLE;
      end
      DRIVE: begin
        if (bus_ack && !req_valid) state_next_s = IDLE;
        else                       state_next_s = DRIVE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake decode; ready deliberately ignores req_valid.
  always_comb begin
    req_ready_s = 1'b0;
    ack_s       = 1'b0;
    case (state_r)
      IDLE:    req_ready_s = 1'b1;
      DRIVE: begin
        req_ready_s = bus_ack;
        ack_s       = bus_ack;
      end
      default: req_ready_s = 1'b0;
    endcase
    accept_s = req_valid & req_ready_s;
  end

  // Source mux; a zero-hot select yields index 0 but data 0.
  always_comb begin
    sel_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!zero_hot_s && (enc_idx_s == 5'(i))) begin
        sel_data_s = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Bus snapshot and valid flag.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      bus_data_r  <= {DATA_WIDTH{1'b0}};
      bus_src_r   <= 5'd0;
      bus_valid_r <= 1'b0;
    end else begin
      bus_valid_r <= (state_next_s == DRIVE);
      if (accept_s) begin
        bus_data_r <= sel_data_s;
        bus_src_r  <= enc_idx_s;
      end
    end
  end

  // Sticky select error: a new error outranks err_clr.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sel_error_r <= 1'b0;
    end else if (accept_s && (zero_hot_s || multi_hot_s)) begin
      sel_error_r <= 1'b1;
    end else if (err_clr) begin
      sel_error_r <= 1'b0;
    end
  end

  // Completed-transfer counter, free-running wrap.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      xfer_count_r <= {CNT_WIDTH{1'b0}};
    end else if (ack_s) begin
      xfer_count_r <= xfer_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign req_ready  = req_ready_s;
  assign BusMuxOut  = bus_data_r;
  assign bus_src    = bus_src_r;
  assign bus_valid  = bus_valid_r;
  assign sel_error  = sel_error_r;
  assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_bus_reader.sv
// Self-checking bench for bus_reader: directed table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_bus_reader;

  localparam int DW = 32;
  localparam int NS = 24;

  logic            clock = 1'b0;
  logic            clear_n;
  logic            req_valid;
  logic [NS-1:0]   req_sel;
  logic            bus_ack;
  logic            err_clr;
  logic [NS*DW-1:0] src_data;
  logic [DW-1:0]   src [NS];

  logic            req_ready, req_ready4;
  logic [DW-1:0]   bus_out, bus_out4;
  logic [4:0]      bus_src, bus_src4;
  logic            bus_valid, bus_valid4;
  logic            sel_error, sel_error4;
  logic [15:0]     xfer_count;
  logic [3:0]      xfer_count4;

  int checks = 0;
  int errors = 0;

  // Reference model state: one snapshot register and a running ack total.
  bit              m_valid;
  logic [DW-1:0]   m_data;
  logic [4:0]      m_src;
  bit              m_err;
  int unsigned     m_acks;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = src[i];
  end

  bus_reader dut (
    .clock(clock), .clear_n(clear_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .src_data(src_data), .BusMuxOut(bus_out),
    .bus_src(bus_src), .bus_valid(bus_valid), .bus_ack(bus_ack),
    .sel_error(sel_error), .err_clr(err_clr), .xfer_count(xfer_count)
  );

  bus_reader #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .clear_n(clear_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready4), .src_data(src_data), .BusMuxOut(bus_out4),
    .bus_src(bus_src4), .bus_valid(bus_valid4), .bus_ack(bus_ack),
    .sel_error(sel_error4), .err_clr(err_clr), .xfer_count(xfer_count4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int ones;
    int low;
    bit acc;
    if (!clear_n) begin
      m_valid = 1'b0; m_data = '0; m_src = '0; m_err = 1'b0; m_acks = 0;
    end else begin
      acc = req_valid && (!m_valid || bus_ack);
      if (m_valid && bus_ack) m_acks++;
      if (acc) begin
        ones = $countones(req_sel);
        low  = 0;
        for (int i = NS - 1; i >= 0; i--) if (req_sel[i]) low = i;
        m_data  = (ones == 0) ? '0 : src[low];
        m_src   = 5'(low);
        m_valid = 1'b1;
        if (ones != 1)    m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end else begin
        if (m_valid && bus_ack) m_valid = 1'b0;
        if (err_clr) m_err = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check ready, update model at posedge, check outputs.
  task automatic step(input bit v, input logic [NS-1:0] sel, input bit ack, input bit clr);
    req_valid = v; req_sel = sel; bus_ack = ack; err_clr = clr;
    #1;
    if (clear_n) begin
      chk("req_ready", {63'd0, req_ready}, {63'd0, !m_valid || ack});
      chk("req_ready4", {63'd0, req_ready4}, {63'd0, !m_valid || ack});
    end
    @(posedge clock);
    model_update();
    #1;
    chk("BusMuxOut", {32'd0, bus_out}, {32'd0, m_data});
    chk("bus_src", {59'd0, bus_src}, {59'd0, m_src});
    chk("bus_valid", {63'd0, bus_valid}, {63'd0, m_valid});
    chk("sel_error", {63'd0, sel_error}, {63'd0, m_err});
    chk("xfer_count", {48'd0, xfer_count}, {48'd0, m_acks[15:0]});
    chk("xfer_count4", {60'd0, xfer_count4}, {60'd0, m_acks[3:0]});
    @(negedge clock);
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    clear_n = 1'b1;
  endtask

  typedef struct {
    bit            v;
    logic [NS-1:0] sel;
    bit            ack;
    bit            clr;
    logic [DW-1:0] e_data;
    logic [4:0]    e_src;
    bit            e_valid;
    bit            e_err;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl [7];
  logic [NS-1:0] multi;

  initial begin
    clear_n = 1'b0; req_valid = 1'b0; req_sel = '0; bus_ack = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NS; i++) src[i] = '0;
    m_valid = 1'b0; m_data = '0; m_src = '0; m_err = 1'b0; m_acks = 0;
    @(negedge clock);

    // Reset then single PC read
    do_reset();
    chk("rst_data", {32'd0, bus_out}, 64'd0);
    chk("rst_valid", {63'd0, bus_valid}, 64'd0);
    chk("rst_cnt", {48'd0, xfer_count}, 64'd0);
    src[20] = 32'h0000_0040;
    step(1'b1, 24'd1 << 20, 1'b0, 1'b0);
    chk("pc_valid", {63'd0, bus_valid}, 64'd1);
    chk("pc_data", {32'd0, bus_out}, 64'h40);
    chk("pc_src", {59'd0, bus_src}, 64'd20);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pc_cnt", {48'd0, xfer_count}, 64'd1);
    chk("pc_idle", {63'd0, bus_valid}, 64'd0);

    // Backpressure: snapshot survives source change
    src[5] = 32'hDEAD_BEEF;
    step(1'b1, 24'd1 << 5, 1'b0, 1'b0);
    src[5] = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 24'd1 << 5, 1'b0, 1'b0);
      chk("bp_data", {32'd0, bus_out}, 64'hDEAD_BEEF);
      chk("bp_cnt", {48'd0, xfer_count}, 64'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_cnt_ack", {48'd0, xfer_count}, 64'd2);

    // Back-to-back R1..R3
    do_reset();
    src[1] = 32'd1; src[2] = 32'd2; src[3] = 32'd3;
    step(1'b1, 24'd1 << 1, 1'b0, 1'b0);
    chk("b2b_1", {32'd0, bus_out}, 64'd1);
    step(1'b1, 24'd1 << 2, 1'b1, 1'b0);
    chk("b2b_2", {32'd0, bus_out}, 64'd2);
    chk("b2b_v2", {63'd0, bus_valid}, 64'd1);
    step(1'b1, 24'd1 << 3, 1'b1, 1'b0);
    chk("b2b_3", {32'd0, bus_out}, 64'd3);
    chk("b2b_v3", {63'd0, bus_valid}, 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("b2b_cnt", {48'd0, xfer_count}, 64'd3);

    // Illegal selects, table-driven with hand-derived expectations
    do_reset();
    src[3] = 32'd7; src[17] = 32'd9; src[20] = 32'h40;
    multi = (24'd1 << 3) | (24'd1 << 17);
    tbl[0] = '{1'b1, 24'd0,     1'b0, 1'b0, 32'd0,  5'd0,  1'b1, 1'b1, 16'd0};
    tbl[1] = '{1'b1, multi,     1'b1, 1'b0, 32'd7,  5'd3,  1'b1, 1'b1, 16'd1};
    tbl[2] = '{1'b0, 24'd0,     1'b1, 1'b1, 32'd7,  5'd3,  1'b0, 1'b0, 16'd2};
    tbl[3] = '{1'b1, multi,     1'b0, 1'b1, 32'd7,  5'd3,  1'b1, 1'b1, 16'd2};
    tbl[4] = '{1'b0, 24'd0,     1'b1, 1'b0, 32'd7,  5'd3,  1'b0, 1'b1, 16'd3};
    tbl[5] = '{1'b1, 24'd1<<20, 1'b0, 1'b1, 32'h40, 5'd20, 1'b1, 1'b0, 16'd3};
    tbl[6] = '{1'b0, 24'd0,     1'b1, 1'b0, 32'h40, 5'd20, 1'b0, 1'b0, 16'd4};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].ack, tbl[i].clr);
      chk("tbl_data", {32'd0, bus_out}, {32'd0, tbl[i].e_data});
      chk("tbl_src", {59'd0, bus_src}, {59'd0, tbl[i].e_src});
      chk("tbl_valid", {63'd0, bus_valid}, {63'd0, tbl[i].e_valid});
      chk("tbl_err", {63'd0, sel_error}, {63'd0, tbl[i].e_err});
      chk("tbl_cnt", {48'd0, xfer_count}, {48'd0, tbl[i].e_cnt});
    end

    // Counter wrap on the 4-bit instance after 17 transfers
    do_reset();
    step(1'b1, 24'd1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 24'd1 << (i % NS), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_cnt4", {60'd0, xfer_count4}, 64'd1);
    chk("wrap_cnt16", {48'd0, xfer_count}, 64'd17);

    // Reset mid-transfer
    src[21] = 32'h0000_CAFE;
    step(1'b1, 24'd1 << 21, 1'b0, 1'b0);
    chk("mdr_data", {32'd0, bus_out}, 64'hCAFE);
    clear_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mid_rst_data", {32'd0, bus_out}, 64'd0);
    chk("mid_rst_valid", {63'd0, bus_valid}, 64'd0);
    chk("mid_rst_cnt", {48'd0, xfer_count}, 64'd0);
    clear_n = 1'b1;
    #1;
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("mid_rst_ack_idle", {48'd0, xfer_count}, 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [NS-1:0] s;
      int k;
      src[$urandom_range(0, NS - 1)] = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0)      s = '0;
      else if (k == 1) s = NS'($urandom);
      else             s = NS'(1) << $urandom_range(0, NS - 1);
      clear_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 2) != 0, s, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    clear_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
